cla_subtractor_pipe: RTL and testbench
======================================

Name: cla_subtractor_pipe

Overview:
- Pipelined unsigned/two's-complement subtractor: Diff = A - B - Bin, with borrow-out. Inverse-direction companion to the team's 8-bit carry lookahead adder.
- Two register stages: low half in stage 1, high half in stage 2, with the inter-half borrow carried in a pipeline register.
- Valid/ready handshake on both sides with full backpressure, one result per cycle sustained.
- Sits between operand sources and consumers in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/result width; must be even and >= 2; split point is WIDTH/2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  stage 1 can accept an operand beat.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow in.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result.
- Diff  output  WIDTH  (A - B - Bin) mod 2^WIDTH.
- Bout  output  1  borrow out; 1 iff A < B + Bin as unbounded unsigned values.

Behaviour:
- Reset (async, immediate): s1_valid=0, s2_valid=0, out_valid=0, Diff=0, Bout=0, all data registers 0. in_ready=1 once rst deasserts.
- A transfer occurs on a clock edge when valid && ready are both 1 on that side. No transfer otherwise.
- Stage 1 register holds:
  - s1_lo = low half of (A - B - Bin), WIDTH/2 bits.
  - s1_b = borrow out of the low half.
  - A and B high halves, unchanged.
  - s1_valid.
- Stage 2 register holds:
  - Diff = {high half of (A_hi - B_hi - s1_b), s1_lo}.
  - Bout = borrow out of the high half.
  - s2_valid, which drives out_valid.
- Flow control:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is a combinational path from out_ready, which is permitted.
- Each edge: if s2_adv, stage 2 loads from stage 1 and s2_valid <= s1_valid. If s1_adv, stage 1 loads the inputs and s1_valid <= in_valid && in_ready.
- Data registers load only on beats whose valid is 1; bubbles do not disturb the held Diff/Bout values.
- Latency: exactly 2 cycles from an in_valid&&in_ready edge to out_valid, when out_ready is held 1.
- Throughput: 1 beat/cycle with out_ready held 1.
- Backpressure: while out_valid && !out_ready, Diff/Bout/out_valid hold stable. Stage 1 can still fill one more beat. After that, in_ready=0. No beat is dropped or duplicated.
- Simultaneous pop and push when the pipe is full: both stages advance in the same cycle and in_ready stays 1.
- Borrow semantics: the subtract is A + ~B + !Bin, and each borrow is the inverted carry of that sum.
- Reset asserted mid-stream: all in-flight beats are discarded and outputs return to reset values immediately. There is no partial-result output.

Optional Feature:
- Macro: CLA_SUB_OVERFLOW_EN.
- With the macro defined:
  - Extra port Ovf, output, 1 bit, pipelined alongside Diff.
  - Ovf = signed two's-complement overflow of A - B - Bin = (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB]).
  - Reset value 0; holds under backpressure like Diff.
- Without the macro: no Ovf port and no related logic.

Test Plan:
- A=0x0F, B=0x01, Bin=0, out_ready=1 -> 2 cycles later out_valid=1, Diff=0x0E, Bout=0.
- A=0x00, B=0x00, Bin=1 -> Diff=0xFF, Bout=1. Then A=0xFF, B=0xFF, Bin=0 -> Diff=0x00, Bout=0.
- A=0x55, B=0xAA, Bin=1 -> Diff=0xAA, Bout=1. With CLA_SUB_OVERFLOW_EN, A=0x80, B=0x01, Bin=0 -> Diff=0x7F, Bout=0, Ovf=1.
- Back-to-back stream of 5 beats with out_ready=1 -> 5 consecutive out_valid cycles, results in order, in_ready never 0.
- Push 3 beats with out_ready=0 -> out_valid=1 with first result held stable, in_ready=0 after 2 accepted beats. Raise out_ready -> remaining beats drain in order; the third beat is accepted once in_ready rises.
- Assert rst while 2 beats are in flight -> out_valid=0, Diff=0, Bout=0 immediately. After release, in_ready=1 and none of the discarded beats appear.

Source files
------------

// File: rtl/cla_subtractor_pipe.sv
// cla_subtractor_pipe: two-stage valid/ready subtractor, Diff = A - B - Bin, low half then high half.
// Optional signed-overflow output enabled by defining CLA_SUB_OVERFLOW_EN.
module cla_subtractor_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
`ifdef CLA_SUB_OVERFLOW_EN
  output logic             Ovf,
`endif
  output logic             Bout
);
  localparam int H = WIDTH / 2;
  logic             s1_valid_q, s2_valid_q, s1_b_q, s1_b_d, bout_q, bout_d, s1_adv, s2_adv;
  logic [H-1:0]     s1_lo_q, s1_lo_d, a_hi_q, b_hi_q;
  logic [H:0]       lo_sum, hi_sum;
  logic [WIDTH-1:0] diff_q, diff_d;
`ifdef CLA_SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif
  // Subtract as A + ~B + !borrow; each borrow is the inverted carry of that sum.
  always_comb begin
    s2_adv  = !s2_valid_q || out_ready;
    s1_adv  = !s1_valid_q || s2_adv;
    lo_sum  = {1'b0, A[H-1:0]} + {1'b0, ~B[H-1:0]} + {{H{1'b0}}, ~Bin};
    hi_sum  = {1'b0, a_hi_q} + {1'b0, ~b_hi_q} + {{H{1'b0}}, ~s1_b_q};
    s1_lo_d = lo_sum[H-1:0];
    s1_b_d  = ~lo_sum[H];
    diff_d  = {hi_sum[H-1:0], s1_lo_q};
    bout_d  = ~hi_sum[H];
`ifdef CLA_SUB_OVERFLOW_EN
    ovf_d   = (a_hi_q[H-1] != b_hi_q[H-1]) && (hi_sum[H-1] != a_hi_q[H-1]);
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_b_q     <= 1'b0;
      s1_lo_q    <= '0;
      a_hi_q     <= '0;
      b_hi_q     <= '0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
`ifdef CLA_SUB_OVERFLOW_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          diff_q <= diff_d;
          bout_q <= bout_d;
`ifdef CLA_SUB_OVERFLOW_EN
          ovf_q  <= ovf_d;
`endif
        end
      end
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_lo_q <= s1_lo_d;
          s1_b_q  <= s1_b_d;
          a_hi_q  <= A[WIDTH-1:H];
          b_hi_q  <= B[WIDTH-1:H];
        end
      end
    end
  end
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign Diff      = diff_q;
  assign Bout      = bout_q;
`ifdef CLA_SUB_OVERFLOW_EN
  assign Ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// tb_cla_subtractor_pipe: directed vectors for the pipelined subtractor (latency, stream, backpressure, reset).
module tb_cla_subtractor_pipe;
  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, Bin = 1'b0;
  logic       in_ready, out_valid, Bout;
  logic [7:0] A = '0, B = '0, Diff;
`ifdef CLA_SUB_OVERFLOW_EN
  logic       Ovf;
`endif
  int checks = 0, errors = 0;
  logic [7:0] sa [5], sb [5], sd [5];
  logic       sbin [5], sbo [5];

  cla_subtractor_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff),
`ifdef CLA_SUB_OVERFLOW_EN
    .Ovf(Ovf),
`endif
    .Bout(Bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bi);
    in_valid = v; A = a; B = b; Bin = bi;
  endtask

  task automatic run1(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [7:0] ed, input logic eb);
    drive(1'b1, a, b, bi);
    chk({tag, "_rdy"}, in_ready, 1);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    chk({tag, "_lat1"}, out_valid, 0);
    step();
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_diff"}, Diff, ed);
    chk({tag, "_bout"}, Bout, eb);
    step();
    chk({tag, "_bubble_vld"}, out_valid, 0);
    chk({tag, "_bubble_hold"}, Diff, ed);
  endtask

  initial begin
    sa = '{8'h10, 8'h03, 8'h80, 8'h7F, 8'hC8};
    sb = '{8'h03, 8'h10, 8'h7F, 8'h80, 8'h37};
    sbin = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    sd = '{8'h0D, 8'hF3, 8'h00, 8'hFF, 8'h90};
    sbo = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    #2;
    chk("rst_vld", out_valid, 0);
    chk("rst_diff", Diff, 0);
    chk("rst_bout", Bout, 0);
    #10 rst = 1'b0;
    chk("rst_rdy", in_ready, 1);

    run1("t0F_01", 8'h0F, 8'h01, 1'b0, 8'h0E, 1'b0);
    run1("t00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    run1("tFF_FF", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    run1("t55_AA_b", 8'h55, 8'hAA, 1'b1, 8'hAA, 1'b1);
    run1("t80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
`ifdef CLA_SUB_OVERFLOW_EN
    chk("ovf_80_01", Ovf, 1);
    run1("t10_03", 8'h10, 8'h03, 1'b0, 8'h0D, 1'b0);
    chk("ovf_10_03", Ovf, 0);
`endif

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, sa[i], sb[i], sbin[i]);
      chk($sformatf("str_rdy%0d", i), in_ready, 1);
      step();
      if (i > 0) begin
        chk($sformatf("str_vld%0d", i - 1), out_valid, 1);
        chk($sformatf("str_diff%0d", i - 1), Diff, sd[i-1]);
        chk($sformatf("str_bout%0d", i - 1), Bout, sbo[i-1]);
      end
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    step();
    chk("str_vld4", out_valid, 1);
    chk("str_diff4", Diff, sd[4]);
    chk("str_bout4", Bout, sbo[4]);
    step();
    chk("str_end", out_valid, 0);

    out_ready = 1'b0;
    drive(1'b1, 8'h40, 8'h01, 1'b0);
    chk("bp_rdy0", in_ready, 1);
    step();
    drive(1'b1, 8'h20, 8'h30, 1'b0);
    chk("bp_rdy1", in_ready, 1);
    step();
    chk("bp_vld", out_valid, 1);
    chk("bp_diff0", Diff, 8'h3F);
    drive(1'b1, 8'h09, 8'h09, 1'b1);
    #1;
    chk("bp_full_rdy", in_ready, 0);
    step();
    chk("bp_hold_vld", out_valid, 1);
    chk("bp_hold_diff", Diff, 8'h3F);
    chk("bp_hold_bout", Bout, 0);
    chk("bp_hold_rdy", in_ready, 0);
    step();
    chk("bp_hold2_diff", Diff, 8'h3F);
    out_ready = 1'b1;
    #1;
    chk("bp_popush_rdy", in_ready, 1);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    chk("bp_d1_vld", out_valid, 1);
    chk("bp_d1_diff", Diff, 8'hF0);
    chk("bp_d1_bout", Bout, 1);
    step();
    chk("bp_d2_vld", out_valid, 1);
    chk("bp_d2_diff", Diff, 8'hFF);
    chk("bp_d2_bout", Bout, 1);
    step();
    chk("bp_end", out_valid, 0);

    drive(1'b1, 8'hAB, 8'h01, 1'b0);
    step();
    drive(1'b1, 8'h01, 8'h02, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    chk("mr_pre_vld", out_valid, 1);
    chk("mr_pre_diff", Diff, 8'hAA);
    #2 rst = 1'b1;
    #1;
    chk("mr_vld", out_valid, 0);
    chk("mr_diff", Diff, 0);
    chk("mr_bout", Bout, 0);
    #3 rst = 1'b0;
    #1;
    chk("mr_rdy", in_ready, 1);
    step();
    chk("mr_post_vld0", out_valid, 0);
    step();
    chk("mr_post_vld1", out_valid, 0);
    chk("mr_post_diff", Diff, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
